// File: rtl/mem_responder.sv
// mem_responder: single-port word memory serving a fetch port and a data port
// with a fixed response latency; the data port wins when both request together.
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_strobe,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dport_q, dport_d, write_q, write_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] mem [DEPTH];
  logic        accept, enter, we, misal, cur_dport, cur_write;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_strb;
  logic [AW-1:0] idx;
  logic        unused_bits;
  // With LATENCY=1 the accepting edge is also the edge entering RESP, so the
  // transaction fields come straight from the inputs while idle.
  always_comb begin
    accept    = state_q == IDLE && (d_req || i_req);
    cur_dport = state_q == IDLE ? d_req : dport_q;
    cur_write = state_q == IDLE ? d_write : write_q;
    cur_addr  = state_q == IDLE ? (d_req ? d_addr : i_addr) : addr_q;
    cur_wdata = state_q == IDLE ? d_wdata : wdata_q;
    cur_strb  = state_q == IDLE ? d_strobe : strb_q;
    idx       = cur_addr[AW+1:2];
    misal     = |cur_addr[1:0];
    enter     = (state_q == WAIT && cnt_q == 4'd0) || (accept && LATENCY == 1);
    we        = reset && enter && cur_dport && cur_write && !misal;
    state_d   = state_q;
    cnt_d     = cnt_q;
    dport_d   = dport_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = LATENCY == 1 ? RESP : WAIT;
        cnt_d   = LATENCY == 1 ? 4'd0 : 4'(LATENCY - 2);
        dport_d = cur_dport;
        write_d = cur_write;
        addr_d  = cur_addr;
        wdata_d = cur_wdata;
        strb_d  = cur_strb;
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP; else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
    if (enter) begin
      rdata_d = (misal || (cur_dport && cur_write)) ? 32'h0 : mem[idx];
      err_d   = cur_dport && misal;
    end
  end
  assign unused_bits = ^cur_addr[31:AW+2];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dport_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dport_q <= dport_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we)
      for (int b = 0; b < 4; b++)
        if (cur_strb[b]) mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
  end
  always_comb begin
    busy      = state_q != IDLE;
    d_data_ok = state_q == RESP && dport_q;
    i_data_ok = state_q == RESP && !dport_q;
    d_rdata   = d_data_ok ? rdata_q : 32'h0;
    i_data    = i_data_ok ? rdata_q : 32'h0;
    d_err     = d_data_ok && err_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench; instance a runs LATENCY=2,
// instance b runs LATENCY=4 for the reset-abort case.
module tb_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ra, ia_req, da_req, da_write, ia_ok, da_ok, da_err, a_busy;
  logic [31:0] ia_addr, ia_data, da_addr, da_wdata, da_rdata;
  logic [3:0]  da_strobe;
  logic        rb, ib_req, db_req, db_write, ib_ok, db_ok, db_err, b_busy;
  logic [31:0] ib_addr, ib_data, db_addr, db_wdata, db_rdata;
  logic [3:0]  db_strobe;

  mem_responder #(.DEPTH(1024), .LATENCY(2)) u_a (
    .clk(clk), .reset(ra), .i_req(ia_req), .i_addr(ia_addr), .i_data_ok(ia_ok),
    .i_data(ia_data), .d_req(da_req), .d_write(da_write), .d_addr(da_addr),
    .d_wdata(da_wdata), .d_strobe(da_strobe), .d_data_ok(da_ok),
    .d_rdata(da_rdata), .d_err(da_err), .busy(a_busy));

  mem_responder #(.DEPTH(1024), .LATENCY(4)) u_b (
    .clk(clk), .reset(rb), .i_req(ib_req), .i_addr(ib_addr), .i_data_ok(ib_ok),
    .i_data(ib_data), .d_req(db_req), .d_write(db_write), .d_addr(db_addr),
    .d_wdata(db_wdata), .d_strobe(db_strobe), .d_data_ok(db_ok),
    .d_rdata(db_rdata), .d_err(db_err), .busy(b_busy));

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chkd;
  } exp_t;

  int          checks = 0, errors = 0;
  logic [31:0] model [int];
  exp_t        dq[$], iq[$];
  exp_t        me;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ra) begin
      if (da_ok) begin
        if (dq.size() == 0) chk("d_unexpected_ok", 32'd1, 32'd0);
        else begin
          me = dq.pop_front();
          chk("d_err", {31'b0, da_err}, {31'b0, me.err});
          if (me.chkd) chk("d_rdata", da_rdata, me.data);
        end
      end else chk("d_idle_zero", da_rdata | {31'b0, da_err}, 32'h0);
      if (ia_ok) begin
        if (iq.size() == 0) chk("i_unexpected_ok", 32'd1, 32'd0);
        else begin
          me = iq.pop_front();
          chk("i_data", ia_data, me.data);
        end
      end else chk("i_idle_zero", ia_data, 32'h0);
      if (da_ok && ia_ok) chk("both_ok", 32'd1, 32'd0);
    end
  end

  task automatic a_data(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st);
    exp_t e;
    int edges = 0, bc = 0, k = int'(addr[11:2]);
    logic [31:0] m;
    e.err  = |addr[1:0];
    e.chkd = !w || e.err;
    e.data = 32'h0;
    if (!e.err && w) begin
      m = model.exists(k) ? model[k] : 32'hx;
      for (int b = 0; b < 4; b++) if (st[b]) m[8*b +: 8] = wd[8*b +: 8];
      model[k] = m;
    end else if (!e.err) e.data = model[k];
    dq.push_back(e);
    da_req = 1'b1; da_write = w; da_addr = addr; da_wdata = wd; da_strobe = st;
    while (edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (a_busy) bc++;
      if (da_ok) break;
    end
    chk("d_latency", edges, 2);
    chk("d_busy_cycles", bc, 2);
    da_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("d_busy_after", {31'b0, a_busy}, 32'h0);
  endtask

  task automatic a_fetch(input logic [31:0] addr);
    exp_t e;
    int edges = 0, bc = 0;
    e.err = 1'b0; e.chkd = 1'b1;
    e.data = |addr[1:0] ? 32'h0 : model[int'(addr[11:2])];
    iq.push_back(e);
    ia_req = 1'b1; ia_addr = addr;
    while (edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (a_busy) bc++;
      if (ia_ok) break;
    end
    chk("i_latency", edges, 2);
    chk("i_busy_cycles", bc, 2);
    ia_req = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic a_both(input logic [31:0] daddr, input logic [31:0] iaddr);
    exp_t e;
    int edges = 0, e2 = 0, early = 0;
    e.err = 1'b0; e.chkd = 1'b1;
    e.data = model[int'(daddr[11:2])];
    dq.push_back(e);
    e.data = model[int'(iaddr[11:2])];
    iq.push_back(e);
    da_req = 1'b1; da_write = 1'b0; da_addr = daddr; da_strobe = 4'h0;
    ia_req = 1'b1; ia_addr = iaddr;
    while (edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (ia_ok) early++;
      if (da_ok) break;
    end
    chk("both_d_latency", edges, 2);
    chk("both_fetch_early", early, 0);
    da_req = 1'b0;
    while (e2 < 20) begin
      @(posedge clk); e2++;
      @(negedge clk);
      if (ia_ok) break;
    end
    chk("both_fetch_after_d", e2, 3);
    ia_req = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic b_access(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp);
    int edges = 0, bc = 0;
    db_req = 1'b1; db_write = w; db_addr = addr; db_wdata = wd; db_strobe = 4'hF;
    while (edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (b_busy) bc++;
      if (db_ok) break;
    end
    chk("b_latency", edges, 4);
    chk("b_busy_cycles", bc, 4);
    if (!w) chk("b_rdata", db_rdata, exp);
    db_req = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int seen;
    ra = 1'b0; rb = 1'b0;
    ia_req = 1'b0; ia_addr = 32'h0; da_req = 1'b0; da_write = 1'b0;
    da_addr = 32'h0; da_wdata = 32'h0; da_strobe = 4'h0;
    ib_req = 1'b0; ib_addr = 32'h0; db_req = 1'b0; db_write = 1'b0;
    db_addr = 32'h0; db_wdata = 32'h0; db_strobe = 4'h0;
    @(negedge clk); @(negedge clk);
    da_req = 1'b1; ia_req = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_busy", {31'b0, a_busy}, 32'h0);
    chk("rst_ok", {30'b0, da_ok, ia_ok}, 32'h0);
    chk("rst_data", da_rdata | ia_data | {31'b0, da_err}, 32'h0);
    da_req = 1'b0; ia_req = 1'b0;
    ra = 1'b1; rb = 1'b1;

    a_data(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    a_fetch(32'h10);
    a_data(1'b1, 32'h20, 32'h11223344, 4'hF);
    a_data(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    a_data(1'b0, 32'h20, 32'h0, 4'h0);
    a_data(1'b1, 32'h20, 32'h99999999, 4'h0);
    a_data(1'b0, 32'h20, 32'h0, 4'h0);
    a_data(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    a_both(32'h20, 32'h30);
    a_data(1'b0, 32'h13, 32'h0, 4'h0);
    a_data(1'b1, 32'h12, 32'h55555555, 4'hF);
    a_data(1'b0, 32'h10, 32'h0, 4'h0);
    a_fetch(32'h02);
    a_data(1'b0, 32'h1010, 32'h0, 4'h0);

    b_access(1'b1, 32'h40, 32'h12345678, 32'h0);
    db_req = 1'b1; db_write = 1'b1; db_addr = 32'h40; db_wdata = 32'hFFFFFFFF; db_strobe = 4'hF;
    @(posedge clk); @(negedge clk);
    chk("b_wait_busy", {31'b0, b_busy}, 32'h1);
    @(posedge clk); @(negedge clk);
    rb = 1'b0; db_req = 1'b0;
    #1;
    chk("b_abort_busy", {31'b0, b_busy}, 32'h0);
    chk("b_abort_ok", {31'b0, db_ok}, 32'h0);
    @(posedge clk); @(negedge clk);
    rb = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      if (db_ok) seen++;
    end
    chk("b_abort_no_ok", seen, 0);
    b_access(1'b0, 32'h40, 32'h0, 32'h12345678);

    chk("d_queue_empty", dq.size(), 0);
    chk("i_queue_empty", iq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
